// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// The serial line is double-flopped into the i_Clock domain, and every receive
// decision uses only the synchronized copy. A falling edge on an idle line starts
// a frame. The start bit is re-checked at its midpoint so that short glitches
// are rejected. The data bits, optional parity bit and stop bit are then sampled
// once per bit period, each at mid-bit.
//
// Optional feature: define UART_RX_PARITY_EN to enable a 9-bit frame. An even
// parity bit then sits between the data bits and the stop bit. A parity
// mismatch reports an error instead of delivering the byte.
//
// Parameters
//   CLKS_PER_BIT  i_Clock cycles per serial bit (1..65535), default 100 MHz/9600
//
// Ports
//   i_Clock       system clock; all state changes on its rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Rx_Serial   asynchronous serial input, idle high, LSB first
//   o_Rx_DV       one-clock pulse: o_Rx_Byte has just been loaded with a new byte
//   o_Rx_Byte     last correctly received byte, held until the next good frame
//   o_Rx_Error    one-clock pulse on a framing (or parity) error
//   o_Rx_Active   high from a validated start bit until the FSM is back in IDLE
//
// Handshake: o_Rx_DV is a pure valid strobe with no ready. The consumer must
// capture o_Rx_Byte on the cycle o_Rx_DV is high, or at any time before the next
// o_Rx_DV pulse. o_Rx_DV and o_Rx_Error are never high on the same clock.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Error,
  output logic       o_Rx_Active
);

  // The start bit is checked half a bit after the edge. Later bits are checked
  // one full bit after that, so every sample lands near the centre of its bit.
  localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    RX_START_BIT  = 3'd1,
    RX_DATA_BITS  = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY_BIT = 3'd3,
`endif
    RX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  data_sr;
  logic        rx_meta;
  logic        rx_sync;
  // Set only when the stop bit was sampled low. CLEANUP then waits for the line
  // to go high again, so a held break reports one error and not a stream of
  // phantom frames. After a good stop bit the line is known to be high.
  // CLEANUP can therefore release after one clock. This lets a start edge
  // that arrives early (inside the stop bit) still be caught.
  logic        wait_high;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif
  logic        frame_ok;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. It resets to the idle (high) level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // Outcome of the stop-bit sample. This only matters in RX_STOP_BIT.
`ifdef UART_RX_PARITY_EN
  assign frame_ok = rx_sync & ~parity_err;
`else
  assign frame_ok = rx_sync;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM. All outputs are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_cnt     <= 16'd0;
      bit_idx     <= 3'd0;
      data_sr     <= 8'h00;
      wait_high   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      o_Rx_DV     <= 1'b0;
      o_Rx_Byte   <= 8'h00;
      o_Rx_Error  <= 1'b0;
      o_Rx_Active <= 1'b0;
    end else begin
      // The strobes default low, so each one is high for exactly one clock.
      o_Rx_DV    <= 1'b0;
      o_Rx_Error <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt     <= 16'd0;
          bit_idx     <= 3'd0;
          o_Rx_Active <= 1'b0;
          if (!rx_sync) begin
            state <= RX_START_BIT;
          end
        end

        RX_START_BIT: begin
          if (clk_cnt == HALF_BIT) begin
            clk_cnt <= 16'd0;
            if (!rx_sync) begin
              state       <= RX_DATA_BITS;
              o_Rx_Active <= 1'b1;
            end else begin
              // The line is already high again: this was a glitch, not a start bit.
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        RX_DATA_BITS: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= 16'd0;
            // Shift in from the top. After eight samples the first (LSB) bit
            // has reached data_sr[0].
            data_sr <= {rx_sync, data_sr[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state   <= RX_PARITY_BIT;
`else
              state   <= RX_STOP_BIT;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY_BIT: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt    <= 16'd0;
            // Even parity: the data bits and the parity bit together hold an
            // even number of ones.
            parity_err <= rx_sync ^ (^data_sr);
            state      <= RX_STOP_BIT;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`endif

        RX_STOP_BIT: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt   <= 16'd0;
            state     <= CLEANUP;
            wait_high <= ~rx_sync;
            if (frame_ok) begin
              o_Rx_Byte <= data_sr;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Rx_Error <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        CLEANUP: begin
          clk_cnt <= 16'd0;
          if (rx_sync || !wait_high) begin
            state       <= IDLE;
            wait_high   <= 1'b0;
            o_Rx_Active <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          clk_cnt     <= 16'd0;
          bit_idx     <= 3'd0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule
